sync_pulse_generator: RTL and testbench

//   Output-side counterpart of the synchronous edge detectors: turns single-cycle

---
 rtl/sync_pulse_generator.sv | 104 ++++++++++
 tb/tb_sync_pulse_generator.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sync_pulse_generator.sv
// Turns single-cycle request strobes into level pulses of HIGH_CYCLES followed by
// a LOW_CYCLES gap; requests that arrive mid-pulse wait in a saturating counter.
module sync_pulse_generator #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int QUEUE_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig,
  output logic               pulse,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);

  localparam int MAXC  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0]   HI_LOAD  = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LO_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [QUEUE_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [QUEUE_W-1:0] pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               last_low, deq, enq;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    last_low = (state_q == S_LOW) && (cnt_q == '0);
    deq      = last_low && (pend_q != '0);
    // A trig on the final gap cycle with nothing queued starts the next pulse directly.
    enq      = trig && (state_q != S_IDLE) && !(last_low && (pend_q == '0));

    case (state_q)
      S_IDLE: if (trig) begin
        state_d = S_HIGH;
        cnt_d   = HI_LOAD;
      end
      S_HIGH: if (cnt_q == '0) begin
        state_d = S_LOW;
        cnt_d   = LO_LOAD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_LOW: if (cnt_q == '0) begin
        if ((pend_q != '0) || trig) begin
          state_d = S_HIGH;
          cnt_d   = HI_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enq && !deq) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + QUEUE_W'(1);
    end else if (deq && !enq) begin
      pend_d = pend_q - QUEUE_W'(1);
    end

    pulse_d = (state_d == S_HIGH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign pulse    = pulse_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sync_pulse_generator.sv
// Directed checks of sync_pulse_generator at default parameters (4 high, 2 low, 3-bit queue).
module tb_sync_pulse_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig;
  logic       pulse, busy, overflow;
  logic [2:0] pending;

  sync_pulse_generator #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .QUEUE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .pulse(pulse),
    .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Bit c of each mask holds the output seen in cycle c (cycle c follows edge c-1).
  logic [127:0] pmask, bmask, omask;
  int           pend_log [0:127];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // trig bit c is sampled at edge c.
  task automatic run(input int n, input logic [127:0] tmask);
    pmask = '0; bmask = '0; omask = '0;
    for (int c = 0; c <= 127; c++) pend_log[c] = 0;
    for (int c = 0; c < n; c++) begin
      trig = tmask[c];
      @(posedge clk);
      #1;
      pmask[c+1]    = pulse;
      bmask[c+1]    = busy;
      omask[c+1]    = overflow;
      pend_log[c+1] = int'(pending);
    end
    trig = 1'b0;
  endtask

  // cnt pulses of 4 high cycles with period 6, first one in cycle start.
  function automatic logic [127:0] train(input int start, input int cnt);
    logic [127:0] m = '0;
    for (int i = 0; i < cnt; i++)
      for (int j = 0; j < 4; j++) m[start + 6*i + j] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    rst_n = 1'b0;
    trig  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulse", 128'(pulse), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_pending", 128'(pending), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    #3 rst_n = 1'b1;

    // single request
    run(8, 128'h1);
    chk("t1_pulse", pmask, train(1, 1));
    chk("t1_busy", bmask, span(1, 6));

    // three back-to-back requests, two queued
    run(21, 128'h7);
    chk("t2_pulse", pmask, train(1, 3));
    chk("t2_busy", bmask, span(1, 18));
    chk("t2_pend_c2", 128'(pend_log[2]), 128'(1));
    chk("t2_pend_c3", 128'(pend_log[3]), 128'(2));
    chk("t2_pend_c7", 128'(pend_log[7]), 128'(1));
    chk("t2_pend_c13", 128'(pend_log[13]), 128'(0));

    // trig only on the last gap cycle: back-to-back pulse, busy stays high
    run(14, 128'h41);
    chk("t4_pulse", pmask, train(1, 2));
    chk("t4_busy", bmask, span(1, 12));
    chk("t4_pend_c7", 128'(pend_log[7]), 128'(0));

    // trig on the dequeue edge with two queued: count unchanged
    run(26, 128'h47);
    chk("t6_pend_c7", 128'(pend_log[7]), 128'(2));
    chk("t6_pend_c13", 128'(pend_log[13]), 128'(1));
    chk("t6_pend_c19", 128'(pend_log[19]), 128'(0));
    chk("t6_pulse", pmask, train(1, 4));
    chk("t6_busy", bmask, span(1, 24));

    // trig held edges 0-9: edge 6 dequeues and enqueues together, edges 7,8 fill
    // the queue to 7 and edge 9 is dropped -> 9 accepted requests, 9 pulses
    run(60, 128'h3FF);
    chk("t3_pend_c6", 128'(pend_log[6]), 128'(5));
    chk("t3_pend_c9", 128'(pend_log[9]), 128'(7));
    chk("t3_pend_c10", 128'(pend_log[10]), 128'(7));
    chk("t3_ovf", omask, span(10, 60));
    chk("t3_pulse", pmask, train(1, 9));
    chk("t3_busy", bmask, span(1, 54));

    // async reset in the second cycle of the second pulse, three queued
    run(8, 128'h1F);
    chk("t5_pre_pend", 128'(pending), 128'(3));
    chk("t5_pre_pulse", 128'(pulse), 128'(1));
    chk("t5_pre_ovf", 128'(overflow), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_pulse", 128'(pulse), 128'(0));
    chk("t5_rst_busy", 128'(busy), 128'(0));
    chk("t5_rst_pending", 128'(pending), 128'(0));
    chk("t5_rst_ovf", 128'(overflow), 128'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    run(6, 128'h0);
    chk("t5_idle_pulse", pmask, 128'(0));
    chk("t5_idle_busy", bmask, 128'(0));
    run(3, 128'h1);
    chk("t5_restart", pmask, 128'hE);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
